wt_mem_req_arbiter: RTL

Shares the single memory-side adapter port between the instruction-cache and data-cache miss/write interfaces. Performs round-robin arbitration and registers the winning request toward the adapter. Remaps each requester's transaction ID onto a pool of downstream IDs so that returns can be routed back to the correct cache with the original ID restored. Sits between the cva6_icache/wt_dcache memory ports and the AXI/L15 adapter.

---
 rtl/wt_cache_pkg.sv | 39 +++
 rtl/wt_arb_tid_table.sv | 62 ++++++
 rtl/wt_mem_req_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and sizing for the write-through cache memory request arbiter.
// The tid fields are wide enough to hold either a requester ID or a downstream ID.
package wt_cache_pkg;

  localparam int NumTx       = 8;
  localparam int TxIdWidth   = 3;
  localparam int ReqTidWidth = 2;
  localparam int ArbTidWidth = (TxIdWidth > ReqTidWidth) ? TxIdWidth : ReqTidWidth;

  typedef struct packed {
    logic [63:0]            addr;
    logic [63:0]            wdata;
    logic [2:0]             size;
    logic                   is_write;
    logic [ArbTidWidth-1:0] tid;
  } arb_req_t;

  typedef struct packed {
    logic [127:0]           rdata;
    logic [ArbTidWidth-1:0] tid;
    logic                   is_write;
  } arb_rtrn_t;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } arb_owner_e;

  // Scans downward so the last hit is the lowest-index free entry.
  function automatic logic [TxIdWidth-1:0] lowest_free(input logic [NumTx-1:0] valid);
    logic [TxIdWidth-1:0] idx;
    idx = '0;
    for (int i = NumTx - 1; i >= 0; i--) begin
      if (!valid[i]) idx = TxIdWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wt_arb_tid_table.sv
// Downstream transaction ID table: allocates the lowest free ID, remembers the
// owning cache and its original tid, and frees the entry when its return arrives.
module wt_arb_tid_table
  import wt_cache_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alloc_req_i,
  input  arb_owner_e             alloc_owner_i,
  input  logic [ArbTidWidth-1:0] alloc_tid_i,
  output logic [TxIdWidth-1:0]   alloc_idx_o,
  output logic                   full_o,
  input  logic [TxIdWidth-1:0]   lookup_tid_i,
  output logic                   lookup_valid_o,
  output arb_owner_e             lookup_owner_o,
  output logic [ArbTidWidth-1:0] lookup_orig_tid_o,
  input  logic                   free_i,
  output logic                   any_valid_o
);

  logic [NumTx-1:0]       valid_q, valid_d;
  arb_owner_e             owner_q [NumTx];
  arb_owner_e             owner_d [NumTx];
  logic [ArbTidWidth-1:0] orig_tid_q [NumTx];
  logic [ArbTidWidth-1:0] orig_tid_d [NumTx];

  assign full_o            = &valid_q;
  assign any_valid_o       = |valid_q;
  assign alloc_idx_o       = lowest_free(valid_q);
  assign lookup_valid_o    = valid_q[lookup_tid_i];
  assign lookup_owner_o    = owner_q[lookup_tid_i];
  assign lookup_orig_tid_o = orig_tid_q[lookup_tid_i];

  // Allocation works off the registered valids, so an entry freed this cycle
  // only becomes allocatable on the next one.
  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    orig_tid_d = orig_tid_q;
    if (free_i) begin
      valid_d[lookup_tid_i] = 1'b0;
    end
    if (alloc_req_i && !full_o) begin
      valid_d[alloc_idx_o]    = 1'b1;
      owner_d[alloc_idx_o]    = alloc_owner_i;
      orig_tid_d[alloc_idx_o] = alloc_tid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      owner_q    <= '{default: ARB_ICACHE};
      orig_tid_q <= '{default: '0};
    end else begin
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      orig_tid_q <= orig_tid_d;
    end
  end

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// Arbitrates icache/dcache requests onto one memory adapter port with ID remapping.
// Build option WT_MEM_ARB_DCACHE_PRIO_EN replaces round-robin with fixed dcache priority.
module wt_mem_req_arbiter
  import wt_cache_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      icache_req_i,
  output logic      icache_ack_o,
  input  arb_req_t  icache_req_data_i,
  input  logic      dcache_req_i,
  output logic      dcache_ack_o,
  input  arb_req_t  dcache_req_data_i,
  output logic      mem_req_o,
  input  logic      mem_gnt_i,
  output arb_req_t  mem_req_data_o,
  input  logic      mem_rtrn_vld_i,
  input  arb_rtrn_t mem_rtrn_i,
  output logic      icache_rtrn_vld_o,
  output logic      dcache_rtrn_vld_o,
  output arb_rtrn_t rtrn_o,
  output logic      busy_o,
  output logic      err_o
);

  logic                   oreg_valid_q, oreg_valid_d;
  arb_req_t               oreg_data_q, oreg_data_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   grant_dcache;
  arb_req_t               sel_data;
  logic                   full;
  logic [TxIdWidth-1:0]   alloc_idx;
  logic                   lookup_valid;
  arb_owner_e             lookup_owner;
  logic [ArbTidWidth-1:0] lookup_orig_tid;
  logic                   table_busy;
  logic                   rtrn_hit;

  assign accept   = !rst_i && (!oreg_valid_q || mem_gnt_i) && !full &&
                    (icache_req_i || dcache_req_i);
  assign sel_data = grant_dcache ? dcache_req_data_i : icache_req_data_i;
  assign rtrn_hit = !rst_i && mem_rtrn_vld_i && lookup_valid;

`ifdef WT_MEM_ARB_DCACHE_PRIO_EN
  always_comb begin
    grant_dcache = dcache_req_i;
  end
`else
  logic rr_q, rr_d;

  // rr set means dcache wins the next tie; it always points away from the last winner.
  always_comb begin
    grant_dcache = (icache_req_i && dcache_req_i) ? rr_q : dcache_req_i;
    rr_d         = rr_q;
    if (accept) rr_d = ~grant_dcache;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`endif

  always_comb begin
    oreg_valid_d      = oreg_valid_q;
    oreg_data_d       = oreg_data_q;
    icache_ack_o      = accept && !grant_dcache;
    dcache_ack_o      = accept && grant_dcache;
    icache_rtrn_vld_o = rtrn_hit && (lookup_owner == ARB_ICACHE);
    dcache_rtrn_vld_o = rtrn_hit && (lookup_owner == ARB_DCACHE);
    rtrn_o            = mem_rtrn_i;
    rtrn_o.tid        = lookup_orig_tid;
    err_d             = err_q | (mem_rtrn_vld_i && !lookup_valid);
    if (accept) begin
      oreg_valid_d     = 1'b1;
      oreg_data_d      = sel_data;
      oreg_data_d.tid  = ArbTidWidth'(alloc_idx);
    end else if (mem_gnt_i) begin
      oreg_valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oreg_valid_q <= 1'b0;
      oreg_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      oreg_valid_q <= oreg_valid_d;
      oreg_data_q  <= oreg_data_d;
      err_q        <= err_d;
    end
  end

  wt_arb_tid_table u_tid_table (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .alloc_req_i       (accept),
    .alloc_owner_i     (grant_dcache ? ARB_DCACHE : ARB_ICACHE),
    .alloc_tid_i       (sel_data.tid),
    .alloc_idx_o       (alloc_idx),
    .full_o            (full),
    .lookup_tid_i      (mem_rtrn_i.tid[TxIdWidth-1:0]),
    .lookup_valid_o    (lookup_valid),
    .lookup_owner_o    (lookup_owner),
    .lookup_orig_tid_o (lookup_orig_tid),
    .free_i            (rtrn_hit),
    .any_valid_o       (table_busy)
  );

  assign mem_req_o      = oreg_valid_q;
  assign mem_req_data_o = oreg_data_q;
  assign busy_o         = oreg_valid_q | table_busy;
  assign err_o          = err_q;

endmodule
